slave_mem: RTL and testbench
============================

// Module: slave_mem
// PURPOSE
//  Memory-backed bus slave, directly downstream of the bus master stage.
//  - Consumes the master's t_mst request (req/addr/data/cmd).
//  - Answers with t_slv (ack/data) using a four-phase req/ack handshake.
//  - Holds a DEPTH x 32 word store: cmd=1 writes, cmd=0 reads.
//  - Master samples rd.data one cycle after it sees ack, so ack and data are held until req drops.
// PARAMETERS
//  DEPTH        16            number of 32-bit words; power of two, >=2
//  WAIT_CYCLES  2             extra wait states before ack; only used with SLV_WAIT_EN
//  BAD_DATA     32'hDEAD_BEEF read data returned for an out-of-range address
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  in_mst   in   t_mst  request from master: req, addr, data[31:0], cmd (1=write, 0=read)
//  out_slv  out  t_slv  response to master: ack, data[31:0]
//  busy     out  1      high in any state other than IDLE
//  err_cnt  out  8      count of out-of-range accesses; saturates at 8'hFF
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_slv.ack=0, out_slv.data=0, busy=0, err_cnt=0.
//    RAM contents are not reset.
//  Mid-transaction reset aborts the access. A write already committed to RAM stays.
//    If req is still high on release, it is taken as a new request.
//  Address decode:
//    idx = addr[$clog2(DEPTH)-1:0]; in range iff all higher addr bits are 0.
//  FSM states, from pkg_slv::t_slv_st:
//    IDLE: req sampled 1 -> latch addr/cmd/data and issue the RAM access on this edge.
//      Write: RAM[idx] <= data when in range; out-of-range writes are dropped.
//      Next state WAIT if SLV_WAIT_EN and WAIT_CYCLES>0, else RESP.
//    WAIT: down-counter loaded with WAIT_CYCLES-1; go to RESP when it reaches 0.
//    RESP: ack<=1.
//      data <= RAM read value (read, in range), BAD_DATA (read, out of range), or latched write data (write echo).
//      err_cnt += 1 if out of range, saturating. Then go to ACKH.
//    ACKH: hold ack=1 and data stable while req=1.
//      When req is sampled 0: ack<=0 and go to IDLE.
//  Latency, req sampled high to ack high:
//    2 cycles without SLV_WAIT_EN; 2+WAIT_CYCLES with it.
//  out_slv.data keeps its last value after ack falls.
//  A new request is accepted only in IDLE. req=1 on the edge ack falls is not captured until the next IDLE edge.
//  addr/data/cmd are sampled only in IDLE. Changes during a transaction are ignored.
//  RAM: synchronous read, 1-cycle latency, write-first for the same index.
// CONFIGURATION
//  SLV_WAIT_EN defined: WAIT state and counter are present; WAIT_CYCLES (1..15) wait states are inserted.
//  SLV_WAIT_EN undefined: no WAIT state and no counter; WAIT_CYCLES is ignored; fixed 2-cycle latency.
// STRUCTURE
//  pkg_slv:
//    - existing t_slv
//    - add enum t_slv_st {IDLE, WAIT, RESP, ACKH}
//    - add localparam SLV_BAD_DATA default
//  pkg_mst: unchanged; t_mst is reused as-is.
//  Sub-module slv_ram: single-port sync RAM (clk, we, idx, wdata, rdata), DEPTH parameter, no reset.
//  slave_mem holds the FSM, the address decode, the wait counter and err_cnt.
// TESTING
//  1. Write then read:
//     write addr=3 data=32'h1234_5678, then read addr=3 -> ack 2 cycles after req;
//     read data=32'h1234_5678; err_cnt=0.
//  2. Out of range: DEPTH=16, read addr=16 -> data=32'hDEAD_BEEF, err_cnt=1.
//     Write addr=20 -> RAM unchanged, err_cnt=2.
//  3. Handshake hold: keep req high 5 cycles after ack -> ack and data stay constant.
//     Drop req -> ack=0 on the next edge; busy=0.
//  4. SLV_WAIT_EN with WAIT_CYCLES=3: read addr=0 -> ack exactly 5 cycles after req is sampled.
//  5. Reset mid-op: pull rst_n low in WAIT/RESP -> ack=0, data=0, busy=0 immediately (async).
//     A completed write to addr=1 is still readable after reset.
//  6. Back-to-back, driven by the master model:
//     8 reads of addr 0..7 pre-loaded with i*32'h11 -> master buff[i] = i*32'h11; no lost or duplicated ack.

Source files
------------

// File: rtl/slave_mem_pkg.sv
// Shared bus types for the master/slave pair.
//   pkg_mst : t_mst, the request record driven by the bus master stage
//             (req, addr, data[31:0], cmd: 1=write, 0=read).
//   pkg_slv : t_slv, the response record (ack, data[31:0]), the slave FSM
//             state enum t_slv_st and the default out-of-range read value.
// Ports: none (packages only).

package pkg_mst;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] data;
        logic        cmd;
    } t_mst;
endpackage

package pkg_slv;
    typedef struct packed {
        logic        ack;
        logic [31:0] data;
    } t_slv;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ACKH} t_slv_st;

    localparam logic [31:0] SLV_BAD_DATA = 32'hDEAD_BEEF;
    // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
    localparam int          SLV_CNT_W    = 4;
endpackage

// File: rtl/slave_mem_ram.sv
// slv_ram: single-port synchronous RAM, DEPTH x 32, no reset.
// Read latency is one cycle; a write returns the written word on rdata
// (write-first).
// Ports:
//   clk   in  1            rising-edge clock
//   we    in  1            write enable
//   idx   in  log2(DEPTH)  word index
//   wdata in  32           write data
//   rdata out 32           registered read data

module slv_ram #(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
            rdata      <= wdata;
        end else begin
            rdata      <= mem_q[idx];
        end
    end

endmodule

// File: rtl/slave_mem.sv
// slave_mem: memory-backed bus slave behind the bus master stage.
// Accepts a t_mst request in IDLE, performs the RAM access on that edge,
// then answers with a four-phase req/ack handshake: ack and data are held
// until the master drops req.
// Optional feature macro: SLV_WAIT_EN -- when defined, WAIT_CYCLES wait
// states (1..15) are inserted between the access and the response.
// Ports:
//   clk     in  1      rising-edge clock
//   rst_n   in  1      asynchronous active-low reset
//   in_mst  in  t_mst  request from the master
//   out_slv out t_slv  ack/data response
//   busy    out 1      high whenever the FSM is not in IDLE
//   err_cnt out 8      saturating count of out-of-range accesses

module slave_mem
    import pkg_mst::*;
    import pkg_slv::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BAD_DATA    = SLV_BAD_DATA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  t_mst       in_mst,
    output t_slv       out_slv,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    t_slv_st          state_q, state_d;
    logic             ack_q, ack_d;
    logic [31:0]      data_q, data_d;
    logic [7:0]       err_q, err_d;

    // Transaction context captured when a request is accepted.
    logic [IDX_W-1:0] idx_q;
    logic             cmd_q;
    logic             oor_q;
    logic [31:0]      wdata_q;

    logic             in_range;
    logic             accept;
    logic             ram_we;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_rdata;

    assign in_range = (in_mst.addr[31:IDX_W] == '0);
    assign accept   = (state_q == IDLE) && in_mst.req;
    assign ram_we   = accept && in_mst.cmd && in_range;
    // Keep addressing the latched index after acceptance so rdata stays
    // valid through any wait states until RESP consumes it.
    assign ram_idx  = (state_q == IDLE) ? in_mst.addr[IDX_W-1:0] : idx_q;

    slv_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (in_mst.data),
        .rdata (ram_rdata)
    );

`ifdef SLV_WAIT_EN
    logic [SLV_CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_wait_cycles;
    assign unused_wait_cycles = WAIT_CYCLES[0];
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_mst.req) begin
`ifdef SLV_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = SLV_CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef SLV_WAIT_EN
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            RESP: begin
                ack_d   = 1'b1;
                if (cmd_q)      data_d = wdata_q;
                else if (oor_q) data_d = BAD_DATA;
                else            data_d = ram_rdata;
                if (oor_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
                state_d = ACKH;
            end
            ACKH: begin
                if (!in_mst.req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef SLV_WAIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= in_mst.addr[IDX_W-1:0];
            cmd_q   <= in_mst.cmd;
            oor_q   <= !in_range;
            wdata_q <= in_mst.data;
        end
    end

    assign out_slv.ack  = ack_q;
    assign out_slv.data = data_q;
    assign busy         = (state_q != IDLE);
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_slave_mem.sv
module tb_slave_mem;
    import pkg_mst::*;
    import pkg_slv::*;

    localparam int DEPTH = 16;
    localparam int WC    = 3;
`ifdef SLV_WAIT_EN
    localparam int LAT = 2 + WC;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    t_mst       in_mst;
    t_slv       out_slv;
    logic       busy;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(WC), .BAD_DATA(32'hDEAD_BEEF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_mst  (in_mst),
        .out_slv (out_slv),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word array plus saturating error count.
    logic [31:0] m_mem [DEPTH];
    int          m_err = 0;

    function automatic logic [31:0] model(input logic cmd, input logic [31:0] addr,
                                          input logic [31:0] wd);
        if (addr < DEPTH) begin
            if (cmd) begin
                m_mem[addr] = wd;
                return wd;
            end
            return m_mem[addr];
        end
        if (m_err < 255) m_err++;
        return cmd ? wd : 32'hDEAD_BEEF;
    endfunction

    // One full handshake; returns the response data and the number of
    // edges from the sampling edge through the edge that raised ack.
    task automatic txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        in_mst.req  = 1'b1;
        in_mst.cmd  = cmd;
        in_mst.addr = addr;
        in_mst.data = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_slv.ack && lat < 100);
        if (lat >= 100) chk("ack_timeout", {31'b0, out_slv.ack}, 32'd1);
        rd = out_slv.data;
        in_mst.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic op_chk(input string tag, input logic cmd, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic [31:0] exp, rd;
        int lat;
        exp = model(cmd, addr, wd);
        txn(cmd, addr, wd, rd, lat);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, {24'b0, err_cnt}, 32'(m_err));
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_ackfall"}, {31'b0, out_slv.ack}, 32'd0);
    endtask

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] buff [8];
    logic        cnt_en = 1'b0;
    logic        ack_prev = 1'b0;
    int          ack_rises = 0;

    always @(posedge clk) begin
        ack_prev <= out_slv.ack;
        if (cnt_en && out_slv.ack && !ack_prev) ack_rises <= ack_rises + 1;
    end

    initial begin
        logic [31:0] rd, junk;
        int lat, n;

        tbl[0] = '{1'b1, 32'd3,          32'h1234_5678, 32'h1234_5678, 8'd0};
        tbl[1] = '{1'b0, 32'd3,          32'h0,         32'h1234_5678, 8'd0};
        tbl[2] = '{1'b1, 32'd4,          32'hAAAA_5555, 32'hAAAA_5555, 8'd0};
        tbl[3] = '{1'b0, 32'd16,         32'h0,         32'hDEAD_BEEF, 8'd1};
        tbl[4] = '{1'b1, 32'd20,         32'hCAFE_0000, 32'hCAFE_0000, 8'd2};
        tbl[5] = '{1'b0, 32'd4,          32'h0,         32'hAAAA_5555, 8'd2};
        tbl[6] = '{1'b0, 32'h8000_0003,  32'h0,         32'hDEAD_BEEF, 8'd3};
        tbl[7] = '{1'b1, 32'd15,         32'h0F0F_0F0F, 32'h0F0F_0F0F, 8'd3};
        tbl[8] = '{1'b0, 32'd15,         32'h0,         32'h0F0F_0F0F, 8'd3};
        tbl[9] = '{1'b0, 32'd3,          32'h0,         32'h1234_5678, 8'd3};

        in_mst = '0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack",  {31'b0, out_slv.ack}, 32'd0);
        chk("rst_data", out_slv.data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err",  {24'b0, err_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: write/read, out-of-range read and dropped write.
        foreach (tbl[i]) begin
            junk = model(tbl[i].cmd, tbl[i].addr, tbl[i].wd);
            txn(tbl[i].cmd, tbl[i].addr, tbl[i].wd, rd, lat);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_d);
            chk($sformatf("tbl%0d_err", i), {24'b0, err_cnt}, {24'b0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(LAT));
            chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, 32'd0);
        end

        // Handshake hold with request fields changing mid-transaction.
        in_mst.req = 1'b1; in_mst.cmd = 1'b0; in_mst.addr = 32'd3;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_slv.ack && n < 100);
        in_mst.cmd = 1'b1; in_mst.addr = 32'd4; in_mst.data = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_ack", k), {31'b0, out_slv.ack}, 32'd1);
            chk($sformatf("hold%0d_data", k), out_slv.data, 32'h1234_5678);
        end
        in_mst.req = 1'b0;
        @(posedge clk); #1;
        chk("drop_ack",  {31'b0, out_slv.ack}, 32'd0);
        chk("drop_busy", {31'b0, busy}, 32'd0);
        chk("drop_data", out_slv.data, 32'h1234_5678);
        op_chk("after_hold", 1'b0, 32'd4, 32'h0);

        // Asynchronous reset in the middle of a read.
        op_chk("pre_rst_wr", 1'b1, 32'd1, 32'h1111_0001);
        in_mst.req = 1'b1; in_mst.cmd = 1'b0; in_mst.addr = 32'd2;
        @(posedge clk); #1;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack",  {31'b0, out_slv.ack}, 32'd0);
        chk("mid_rst_data", out_slv.data, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_err",  {24'b0, err_cnt}, 32'd0);
        in_mst.req = 1'b0;
        m_err = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op_chk("post_rst_rd", 1'b0, 32'd1, 32'h0);

        // Back-to-back master: data sampled one cycle after ack is seen.
        for (int i = 0; i < 8; i++) op_chk($sformatf("pre%0d", i), 1'b1, 32'(i), 32'(i) * 32'h11);
        ack_rises = 0;
        cnt_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_mst.req = 1'b1; in_mst.cmd = 1'b0; in_mst.addr = 32'(i);
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!out_slv.ack && n < 100);
            @(posedge clk); #1;
            buff[i] = out_slv.data;
            in_mst.req = 1'b0;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (out_slv.ack && n < 100);
        end
        repeat (2) @(posedge clk);
        #1 cnt_en = 1'b0;
        for (int i = 0; i < 8; i++) chk($sformatf("b2b_buff%0d", i), buff[i], 32'(i) * 32'h11);
        chk("b2b_ack_count", 32'(ack_rises), 32'd8);

        // Randomized accesses against the model.
        for (int i = 0; i < DEPTH; i++) op_chk($sformatf("fill%0d", i), 1'b1, 32'(i), $urandom);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(16, 40)) : 32'($urandom_range(0, 15));
            op_chk($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            junk = model(1'b0, 32'd100, 32'h0);
            txn(1'b0, 32'd100, 32'h0, rd, lat);
        end
        chk("sat_err", {24'b0, err_cnt}, 32'(m_err));
        chk("sat_err_ff", {24'b0, err_cnt}, 32'hFF);
        op_chk("sat_hold", 1'b0, 32'd200, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
